// File: rtl/half_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// half_subtractor_pkg
//   Shared definitions for the half_subtractor datapath leaf.
//   - DEFAULT_WIDTH : default operand width (classic 1-bit half subtractor)
//   - HS_MAX_WIDTH  : widest operand the reference helpers accept
//   - hs_result_t   : {bout, diff} pair returned by hs_ref
//   - hs_mask       : low-order mask of a given width
//   - hs_ref        : golden unsigned subtraction a - b with borrow-out
//   - hs_ovf_ref    : golden two's-complement overflow flag of a - b
// -----------------------------------------------------------------------------
package half_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int HS_MAX_WIDTH  = 64;

  typedef struct packed {
    logic                    bout;
    logic [HS_MAX_WIDTH-1:0] diff;
  } hs_result_t;

  // Mask selecting the low `width` bits; saturates at the full container.
  function automatic logic [HS_MAX_WIDTH-1:0] hs_mask(input int unsigned width);
    logic [HS_MAX_WIDTH-1:0] m;
    if (width >= HS_MAX_WIDTH) begin
      m = '1;
    end else begin
      m = (64'd1 << width) - 64'd1;
    end
    return m;
  endfunction

  // Unsigned a - b on width+1 bits: the bit just above the operand width is
  // the borrow, everything below it is the modular difference.
  function automatic hs_result_t hs_ref(input logic [HS_MAX_WIDTH-1:0] a,
                                        input logic [HS_MAX_WIDTH-1:0] b,
                                        input int unsigned             width);
    hs_result_t              r;
    logic [HS_MAX_WIDTH:0]   full;
    logic [HS_MAX_WIDTH-1:0] m;
    m      = hs_mask(width);
    full   = {1'b0, a & m} - {1'b0, b & m};
    r.bout = full[width];
    r.diff = full[HS_MAX_WIDTH-1:0] & m;
    return r;
  endfunction

  // Signed overflow happens when the operands differ in sign and the result
  // sign differs from the minuend's sign.
  function automatic logic hs_ovf_ref(input logic [HS_MAX_WIDTH-1:0] a,
                                      input logic [HS_MAX_WIDTH-1:0] b,
                                      input int unsigned             width);
    hs_result_t r;
    logic       sa;
    logic       sb;
    logic       sd;
    r  = hs_ref(a, b, width);
    sa = a[width-1];
    sb = b[width-1];
    sd = r.diff[width-1];
    return (sa ^ sb) & (sa ^ sd);
  endfunction

endpackage

// File: rtl/half_subtractor_bit.sv
// -----------------------------------------------------------------------------
// half_subtractor_bit
//   One-bit combinational subtractor cell (full subtractor with borrow-in).
//   With bin tied low it degenerates to the classic half subtractor.
// Ports
//   a    in   minuend bit
//   b    in   subtrahend bit
//   bin  in   borrow from the next-lower bit
//   d    out  difference bit
//   bo   out  borrow to the next-higher bit
// -----------------------------------------------------------------------------
module half_subtractor_bit
  import half_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign d       = a_xor_b ^ bin;
  // Borrow is generated when a=0,b=1, and propagated when a==b.
  assign bo      = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/half_subtractor.sv
// -----------------------------------------------------------------------------
// half_subtractor
//   Registered WIDTH-bit unsigned subtractor: {bout, diff} = a - b.
//   Ripple-borrow chain of half_subtractor_bit cells, one pipeline stage,
//   valid-tagged, no backpressure (one result per cycle).
// Parameters
//   WIDTH      operand/result width in bits (>= 1)
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   a/b qualify this cycle
//   a          in   minuend, unsigned, WIDTH bits
//   b          in   subtrahend, unsigned, WIDTH bits
//   out_valid  out  diff/bout hold the result of an accepted pair
//   diff       out  (a - b) mod 2**WIDTH
//   bout       out  1 iff a < b (unsigned)
//   ovf        out  two's-complement overflow of a - b
//                   (only when HALF_SUBTRACTOR_OVF_EN is defined)
// Configuration
//   HALF_SUBTRACTOR_OVF_EN  adds the registered signed-overflow output.
// -----------------------------------------------------------------------------
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
`ifdef HALF_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  // Borrow chain: br[0] is the (absent) borrow-in of bit 0, br[WIDTH] is bout.
  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] diff_next;

  assign br[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      half_subtractor_bit u_bit (
        .a   (a[gi]),
        .b   (b[gi]),
        .bin (br[gi]),
        .d   (diff_next[gi]),
        .bo  (br[gi+1])
      );
    end
  endgenerate

  logic             out_valid_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;

  // Result registers load only on accepted pairs so they hold the last
  // result across idle cycles; out_valid tracks in_valid one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      diff_reg      <= '0;
      bout_reg      <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        diff_reg <= diff_next;
        bout_reg <= br[WIDTH];
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign diff      = diff_reg;
  assign bout      = bout_reg;

`ifdef HALF_SUBTRACTOR_OVF_EN
  logic ovf_next;
  logic ovf_reg;

  // Signed overflow: operand signs differ and result sign differs from a.
  assign ovf_next = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff_next[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (in_valid) begin
      ovf_reg <= ovf_next;
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// -----------------------------------------------------------------------------
// tb_half_subtractor
//   Bench for half_subtractor at WIDTH=1, 8 and 16. A behavioural model
//   (plain integer arithmetic) predicts every output each cycle; directed
//   vectors add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_half_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Per-DUT stimulus, index 0: WIDTH=1, 1: WIDTH=8, 2: WIDTH=16
  int          wid [3] = '{1, 8, 16};
  logic        in_v [3];
  logic [15:0] in_a [3];
  logic [15:0] in_b [3];

  logic        o_v1, o_b1, o_v8, o_b8, o_v16, o_b16;
  logic [0:0]  o_d1;
  logic [7:0]  o_d8;
  logic [15:0] o_d16;
`ifdef HALF_SUBTRACTOR_OVF_EN
  logic        o_o1, o_o8, o_o16;
`endif

  half_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_v[0]), .a(in_a[0][0:0]), .b(in_b[0][0:0]),
    .out_valid(o_v1), .diff(o_d1),
`ifdef HALF_SUBTRACTOR_OVF_EN
    .ovf(o_o1),
`endif
    .bout(o_b1));

  half_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_v[1]), .a(in_a[1][7:0]), .b(in_b[1][7:0]),
    .out_valid(o_v8), .diff(o_d8),
`ifdef HALF_SUBTRACTOR_OVF_EN
    .ovf(o_o8),
`endif
    .bout(o_b8));

  half_subtractor #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_v[2]), .a(in_a[2]), .b(in_b[2]),
    .out_valid(o_v16), .diff(o_d16),
`ifdef HALF_SUBTRACTOR_OVF_EN
    .ovf(o_o16),
`endif
    .bout(o_b16));

  int checks = 0;
  int errors = 0;

  // Model state (what the outputs must show after the next edge)
  logic        m_v [3];
  logic [15:0] m_d [3];
  logic        m_b [3];
  logic        m_o [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Signed overflow from integer ranges: true result outside [-2^(w-1), 2^(w-1)-1].
  function automatic logic sov(input int a, input int b, input int w);
    int sa, sb, r, half;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - 2 * half : a;
    sb = (b >= half) ? b - 2 * half : b;
    r  = sa - sb;
    return (r < -half) || (r > half - 1);
  endfunction

  // Advance the model for the coming edge, clock, then compare every output.
  task automatic step();
    logic [15:0] ad [3];
    logic        av [3];
    logic        ab [3];
    int ai, bi, mask;
    for (int k = 0; k < 3; k++) begin
      mask = (1 << wid[k]) - 1;
      ai   = int'(in_a[k]) & mask;
      bi   = int'(in_b[k]) & mask;
      if (rst) begin
        m_v[k] = 1'b0; m_d[k] = '0; m_b[k] = 1'b0; m_o[k] = 1'b0;
      end else if (in_v[k]) begin
        m_v[k] = 1'b1;
        m_d[k] = 16'((ai - bi) & mask);
        m_b[k] = (ai < bi);
        m_o[k] = sov(ai, bi, wid[k]);
      end else begin
        m_v[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    av[0] = o_v1;  ad[0] = {15'd0, o_d1}; ab[0] = o_b1;
    av[1] = o_v8;  ad[1] = {8'd0, o_d8};  ab[1] = o_b8;
    av[2] = o_v16; ad[2] = o_d16;         ab[2] = o_b16;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w%0d_out_valid", wid[k]), {31'd0, av[k]}, {31'd0, m_v[k]});
      chk($sformatf("w%0d_diff", wid[k]), {16'd0, ad[k]}, {16'd0, m_d[k]});
      chk($sformatf("w%0d_bout", wid[k]), {31'd0, ab[k]}, {31'd0, m_b[k]});
    end
`ifdef HALF_SUBTRACTOR_OVF_EN
    chk("w1_ovf", {31'd0, o_o1}, {31'd0, m_o[0]});
    chk("w8_ovf", {31'd0, o_o8}, {31'd0, m_o[1]});
    chk("w16_ovf", {31'd0, o_o16}, {31'd0, m_o[2]});
`endif
  endtask

  // Hand-computed literal: pins both the model and the DUT.
  task automatic lit(input int k, input string name, input logic v,
                     input logic [15:0] d, input logic bo);
    logic [15:0] act_d;
    logic        act_v, act_b;
    case (k)
      0: begin act_v = o_v1; act_d = {15'd0, o_d1}; act_b = o_b1; end
      1: begin act_v = o_v8; act_d = {8'd0, o_d8};  act_b = o_b8; end
      default: begin act_v = o_v16; act_d = o_d16; act_b = o_b16; end
    endcase
    chk({name, "_model"}, {15'd0, m_v[k], m_d[k], m_b[k]}, {15'd0, v, d, bo});
    chk({name, "_v"}, {31'd0, act_v}, {31'd0, v});
    chk({name, "_d"}, {16'd0, act_d}, {16'd0, d});
    chk({name, "_b"}, {31'd0, act_b}, {31'd0, bo});
  endtask

  task automatic drive(input int k, input logic v, input logic [15:0] a, input logic [15:0] b);
    in_v[k] = v; in_a[k] = a; in_b[k] = b;
  endtask

  // Directed tables
  logic [1:0]  w1_ab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0]  w1_ex [4] = '{2'b00, 2'b11, 2'b10, 2'b00};  // {diff, bout}
  logic [7:0]  w8_a  [6] = '{8'h00, 8'hFF, 8'h5A, 8'h80, 8'h7F, 8'h10};
  logic [7:0]  w8_b  [6] = '{8'hFF, 8'h00, 8'h5A, 8'h01, 8'hFF, 8'h01};
  logic [7:0]  w8_d  [6] = '{8'h01, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h0F};
  logic        w8_bo [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        w8_ov [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0]  bb_a  [3] = '{8'h03, 8'h01, 8'h40};
  logic [7:0]  bb_b  [3] = '{8'h01, 8'h03, 8'h20};
  logic [7:0]  bb_d  [3] = '{8'h02, 8'hFE, 8'h20};
  logic        bb_bo [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 16'd0, 16'd0);
    for (int k = 0; k < 3; k++) begin m_v[k] = 0; m_d[k] = 0; m_b[k] = 0; m_o[k] = 0; end
    @(posedge clk);
    #1;

    // Reset wins over a simultaneous valid pair
    drive(0, 1'b1, 16'd0, 16'd1);
    step();
    lit(0, "rst_w1", 1'b0, 16'd0, 1'b0);
    rst = 1'b0;
    step();
    lit(0, "first_after_rst", 1'b1, 16'd1, 1'b1);

    // WIDTH=1 exhaustive
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, {15'd0, w1_ab[i][1]}, {15'd0, w1_ab[i][0]});
      step();
      lit(0, $sformatf("w1_ab%0d", i), 1'b1, {15'd0, w1_ex[i][1]}, w1_ex[i][0]);
    end
    drive(0, 1'b0, 16'd0, 16'd0);

    // WIDTH=8 boundaries and signed-overflow cases
    for (int i = 0; i < 6; i++) begin
      drive(1, 1'b1, {8'd0, w8_a[i]}, {8'd0, w8_b[i]});
      step();
      lit(1, $sformatf("w8_bnd%0d", i), 1'b1, {8'd0, w8_d[i]}, w8_bo[i]);
`ifdef HALF_SUBTRACTOR_OVF_EN
      chk($sformatf("w8_bnd%0d_ovf", i), {31'd0, o_o8}, {31'd0, w8_ov[i]});
`else
      chk($sformatf("w8_bnd%0d_ovf_model", i), {31'd0, sov(int'(w8_a[i]), int'(w8_b[i]), 8)},
          {31'd0, w8_ov[i]});
`endif
    end

    // Back-to-back pairs, then a gap: results hold while out_valid drops
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, {8'd0, bb_a[i]}, {8'd0, bb_b[i]});
      step();
      lit(1, $sformatf("b2b%0d", i), 1'b1, {8'd0, bb_d[i]}, bb_bo[i]);
    end
    drive(1, 1'b0, 16'hFFFF, 16'h1234);
    step();
    lit(1, "gap0", 1'b0, 16'h0020, 1'b0);
    step();
    lit(1, "gap1", 1'b0, 16'h0020, 1'b0);

    // Randomised traffic on all widths with occasional reset pulses
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < 3; k++)
        drive(k, 1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
